// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types and helpers for the one-hot decoder with scan mode.
//   state_e     : controller state (OFF, DIRECT, SCAN)
//   onehot_enc  : index -> one-hot vector, all-zero when index >= width
//   cnt_width   : counter width for a modulus n, never less than one bit
// -----------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  // Widest one-hot vector the encoder can produce; callers truncate the
  // result to their own width with a size cast.
  localparam int unsigned ONEHOT_MAX_W = 64;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot_enc(
    input int unsigned index,
    input int unsigned width
  );
    logic [ONEHOT_MAX_W-1:0] v;
    v = ONEHOT_MAX_W'(1) << index;
    if (index >= width) begin
      v = '0;
    end
    return v;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// -----------------------------------------------------------------------------
// scan_counter
// Dwell counter plus position counter for the scan sweep. The dwell counter
// counts up to DWELL-1, then clears and advances the position, which wraps
// from N_OUT-1 back to 0.
//
// Ports
//   clk          : clock
//   rst          : synchronous active-high reset
//   clear_i      : force dwell and position to zero at the next edge
//   step_en_i    : advance the dwell counter at the next edge
//   pos_o        : position that will be in effect after the next edge
//   wrap_next_o  : the next edge wraps the position from N_OUT-1 to 0
// -----------------------------------------------------------------------------
module scan_counter
  import decoder_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int DWELL = 4,
  localparam int PW   = cnt_width(N_OUT),
  localparam int DW   = cnt_width(DWELL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          step_en_i,
  output logic [PW-1:0] pos_o,
  output logic          wrap_next_o
);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(N_OUT - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          wrap_d;

  always_comb begin
    dwell_d = dwell_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    if (clear_i) begin
      dwell_d = '0;
      pos_d   = '0;
    end else if (step_en_i) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        if (pos_q == POS_LAST) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      pos_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      pos_q   <= pos_d;
    end
  end

  // Look-ahead outputs let the top register y/idx/wrap in the same edge
  // that moves the counter, so the outputs and the counter never skew.
  assign pos_o       = pos_d;
  assign wrap_next_o = wrap_d;

endmodule

// File: rtl/onehot_decoder_scan.sv
// -----------------------------------------------------------------------------
// onehot_decoder_scan
// Registered binary-to-one-hot decoder with enable, range check and an
// autonomous scan mode that walks a single active line across all outputs,
// holding each for DWELL cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// OFF    | en=0; all outputs low, scan position held at zero
// DIRECT | en=1, mode=0; y decodes sel, err flags sel >= N_OUT
// SCAN   | en=1, mode=1; y walks 0..N_OUT-1, DWELL cycles per line
//
// Ports
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, overrides everything
//   en   : block enable
//   mode : 0 = direct decode, 1 = scan
//   sel  : direct-mode select index
//   y    : registered one-hot lines (all-zero when inactive)
//   idx  : registered index of the active line, 0 when none
//   err  : registered out-of-range flag for direct mode
//   wrap : registered one-cycle pulse at the start of each repeat sweep
//
// Parameter limits: N_SEL >= 1, 2 <= N_OUT <= 2**N_SEL (and <= 64),
// DWELL >= 1.
// -----------------------------------------------------------------------------
module onehot_decoder_scan
  import decoder_pkg::*;
#(
  parameter int N_SEL = 2,
  parameter int N_OUT = 4,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [N_SEL-1:0] sel,
  output logic [N_OUT-1:0] y,
  output logic [N_SEL-1:0] idx,
  output logic             err,
  output logic             wrap
);

  localparam int PW = cnt_width(N_OUT);

  state_e           state_q, state_d;
  logic [N_OUT-1:0] y_q, y_d;
  logic [N_SEL-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;

  logic             cnt_step;
  logic             cnt_clear;
  logic [PW-1:0]    scan_pos;
  logic             scan_wrap;
  logic             sel_in_range;

  // The counter only advances while we stay in SCAN; every other cycle
  // (including the entry edge) parks it at position 0, so re-entry always
  // starts a fresh sweep.
  assign cnt_step     = (state_q == ST_SCAN) && (state_d == ST_SCAN);
  assign cnt_clear    = !cnt_step;
  assign sel_in_range = 32'(sel) < 32'(N_OUT);

  scan_counter #(
    .N_OUT (N_OUT),
    .DWELL (DWELL)
  ) u_scan_counter (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (cnt_clear),
    .step_en_i   (cnt_step),
    .pos_o       (scan_pos),
    .wrap_next_o (scan_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from the next state so a mode change is visible
  // right after the edge that samples it, with no all-zero gap.
  always_comb begin
    state_d = ST_OFF;
    y_d     = '0;
    idx_d   = '0;
    err_d   = 1'b0;
    wrap_d  = 1'b0;

    if (en) begin
      state_d = mode ? ST_SCAN : ST_DIRECT;
    end

    case (state_d)
      ST_DIRECT: begin
        if (sel_in_range) begin
          y_d   = N_OUT'(onehot_enc(32'(sel), N_OUT));
          idx_d = sel;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_SCAN: begin
        y_d    = N_OUT'(onehot_enc(32'(scan_pos), N_OUT));
        idx_d  = N_SEL'(scan_pos);
        wrap_d = scan_wrap;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign err  = err_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_scan.sv
module tb_onehot_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [1:0] sel_a;
  logic [2:0] sel_b;

  logic [3:0] y_a;  logic [1:0] idx_a; logic err_a, wrap_a;
  logic [4:0] y_b;  logic [2:0] idx_b; logic err_b, wrap_b;
  logic [3:0] y_c;  logic [1:0] idx_c; logic err_c, wrap_c;

  int n_checks = 0;
  int n_errors = 0;

  // Model scan time per instance: -1 when not scanning, else edges since entry.
  int t_a = -1, t_b = -1, t_c = -1;

  always #5 clk = ~clk;

  onehot_decoder_scan #(.N_SEL(2), .N_OUT(4), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_a),
    .y(y_a), .idx(idx_a), .err(err_a), .wrap(wrap_a));

  onehot_decoder_scan #(.N_SEL(3), .N_OUT(5), .DWELL(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_b),
    .y(y_b), .idx(idx_b), .err(err_b), .wrap(wrap_b));

  onehot_decoder_scan #(.N_SEL(2), .N_OUT(4), .DWELL(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_a),
    .y(y_c), .idx(idx_c), .err(err_c), .wrap(wrap_c));

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: scan position is simply (time in scan / DWELL) mod N_OUT,
  // and a repeat sweep starts whenever that time is a nonzero multiple of
  // one full sweep.
  task automatic model_step(input int n_out, input int dwell, input int s,
                            inout int t, output int ey, output int eidx,
                            output int eerr, output int ewrap);
    int p;
    ey = 0; eidx = 0; eerr = 0; ewrap = 0;
    if (rst || !en) begin
      t = -1;
    end else if (!mode) begin
      t = -1;
      if (s < n_out) begin
        ey = 1 << s;
        eidx = s;
      end else begin
        eerr = 1;
      end
    end else begin
      t = (t < 0) ? 0 : t + 1;
      p = (t / dwell) % n_out;
      ey = 1 << p;
      eidx = p;
      ewrap = (t > 0 && (t % (n_out * dwell)) == 0) ? 1 : 0;
    end
  endtask

  task automatic compare_dut(input string name, input int y, input int idx,
                             input int err, input int wrap, input int ey,
                             input int eidx, input int eerr, input int ewrap);
    check_val({name, "_y"}, y, ey);
    check_val({name, "_idx"}, idx, eidx);
    check_val({name, "_err"}, err, eerr);
    check_val({name, "_wrap"}, wrap, ewrap);
    check_val({name, "_onehot"}, ($countones(y) <= 1) ? 1 : 0, 1);
    check_val({name, "_idx_cons"},
              (y == 0) ? ((idx == 0) ? 1 : 0) : ((y == (1 << idx)) ? 1 : 0), 1);
  endtask

  task automatic tick();
    int ey, eidx, eerr, ewrap;
    @(posedge clk);
    #1;
    model_step(4, 4, int'(sel_a), t_a, ey, eidx, eerr, ewrap);
    compare_dut("a", int'(y_a), int'(idx_a), int'(err_a), int'(wrap_a), ey, eidx, eerr, ewrap);
    model_step(5, 4, int'(sel_b), t_b, ey, eidx, eerr, ewrap);
    compare_dut("b", int'(y_b), int'(idx_b), int'(err_b), int'(wrap_b), ey, eidx, eerr, ewrap);
    model_step(4, 1, int'(sel_a), t_c, ey, eidx, eerr, ewrap);
    compare_dut("c", int'(y_c), int'(idx_c), int'(err_c), int'(wrap_c), ey, eidx, eerr, ewrap);
  endtask

  logic [3:0] dir_tab [4];

  initial begin
    dir_tab[0] = 4'b0001; dir_tab[1] = 4'b0010;
    dir_tab[2] = 4'b0100; dir_tab[3] = 4'b1000;

    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_a = '0; sel_b = '0;
    tick(); tick();
    check_val("rst_y", y_a, 0);
    check_val("rst_idx", idx_a, 0);
    check_val("rst_err", err_a, 0);
    check_val("rst_wrap", wrap_a, 0);
    rst = 1'b0;

    // Direct decode of every select.
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      tick();
      check_val("dir_y", y_a, dir_tab[i]);
      check_val("dir_idx", idx_a, i);
      check_val("dir_err", err_a, 0);
    end

    // Out-of-range select on the 5-of-8 instance.
    sel_b = 3'd4; tick();
    check_val("oor4_y", y_b, 5'b10000);
    check_val("oor4_err", err_b, 0);
    sel_b = 3'd6; tick();
    check_val("oor6_y", y_b, 0);
    check_val("oor6_idx", idx_b, 0);
    check_val("oor6_err", err_b, 1);
    sel_b = 3'd2; tick();
    check_val("oor2_err", err_b, 0);
    check_val("oor2_y", y_b, 5'b00100);

    // Full scan sweep, 40 cycles.
    en = 1'b0; tick();
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      check_val("scan_y", y_a, 1 << ((k / 4) % 4));
      check_val("scan_wrap", wrap_a, (k == 16 || k == 32) ? 1 : 0);
      check_val("scan_nz", (y_a != 0) ? 1 : 0, 1);
      if (k < 8) check_val("rot_y", y_c, 1 << (k % 4));
    end

    // DWELL=1 with enable drop at position 2.
    en = 1'b0; tick();
    en = 1'b1;
    tick(); tick(); tick();
    check_val("d1_pos2", y_c, 4'b0100);
    en = 1'b0; tick();
    check_val("d1_off", y_c, 0);
    en = 1'b1; tick();
    check_val("d1_reen", y_c, 4'b0001);

    // Mid-sweep mode switches and reset.
    for (int k = 0; k < 12; k++) tick();
    check_val("mid_pos3", y_a, 4'b1000);
    mode = 1'b0; sel_a = 2'd1; tick();
    check_val("mid_dir_y", y_a, 4'b0010);
    check_val("mid_dir_idx", idx_a, 1);
    mode = 1'b1; tick();
    check_val("mid_rescan", y_a, 4'b0001);
    for (int k = 0; k < 15; k++) tick();
    check_val("mid_pre_rst", y_a, 4'b1000);
    rst = 1'b1; tick();
    check_val("mid_rst_y", y_a, 0);
    check_val("mid_rst_idx", idx_a, 0);
    check_val("mid_rst_wrap", wrap_a, 0);
    check_val("mid_rst_err", err_a, 0);
    rst = 1'b0; tick();
    check_val("post_rst_y", y_a, 4'b0001);
    check_val("post_rst_wrap", wrap_a, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      rst   = ($urandom_range(0, 99) < 3);
      en    = ($urandom_range(0, 99) < 90);
      if ($urandom_range(0, 99) < 8) mode = ~mode;
      sel_a = 2'($urandom_range(0, 3));
      sel_b = 3'($urandom_range(0, 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
